// File: rtl/data_memory_arbiter.sv
// Two-requester arbiter/sequencer in front of a single-ported DataMemory.
// Each transaction occupies one ACCESS cycle on the memory bus, then one RESP cycle
// in which the owning port receives its Ack. A waiting port is launched straight out
// of RESP, so two busy requesters are served alternately, one access every two cycles.
module data_memory_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter bit          FIXED_PRIO = 1'b0,
    parameter int unsigned CNT_W      = 8
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Req0,
    input  logic              Req1,
    input  logic              We0,
    input  logic              We1,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic [DATA_W-1:0] WData0,
    input  logic [DATA_W-1:0] WData1,
    output logic              Ack0,
    output logic              Ack1,
    output logic [DATA_W-1:0] RData0,
    output logic [DATA_W-1:0] RData1,
    output logic [ADDR_W-1:0] Mem_Adresa,
    output logic [DATA_W-1:0] Mem_WData,
    output logic              Mem_Write,
    output logic              Mem_Read,
    input  logic [DATA_W-1:0] Mem_RData,
    output logic              Busy,
    output logic [CNT_W-1:0]  GrantCnt0,
    output logic [CNT_W-1:0]  GrantCnt1
);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d;     // port that owns the latched transaction
    logic              rr_q, rr_d;       // port favoured on the next IDLE conflict
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic [CNT_W-1:0]  cnt0_q, cnt0_d;
    logic [CNT_W-1:0]  cnt1_q, cnt1_d;

    logic              launch;
    logic              launch_port;

    // Next-state: arbitration, request latching, read capture and grant counting.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_d        = rr_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        cnt0_d      = cnt0_q;
        cnt1_d      = cnt1_q;
        launch      = 1'b0;
        launch_port = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (Req0 || Req1) begin
                    launch = 1'b1;
                    if (Req0 && Req1) begin
                        launch_port = FIXED_PRIO ? 1'b0 : rr_q;
                    end else begin
                        launch_port = Req1;
                    end
                end
            end
            StAccess: begin
                state_d = StResp;
                if (!we_q) begin
                    if (gnt_q) begin
                        rdata1_d = Mem_RData;
                    end else begin
                        rdata0_d = Mem_RData;
                    end
                end
                // Counted at the closing edge of ACCESS so the new value shows with Ack.
                if (gnt_q) begin
                    if (cnt1_q != '1) begin
                        cnt1_d = cnt1_q + 1'b1;
                    end
                end else begin
                    if (cnt0_q != '1) begin
                        cnt0_d = cnt0_q + 1'b1;
                    end
                end
            end
            StResp: begin
                // The port being acked is masked; only the other one may launch here.
                rr_d    = ~gnt_q;
                state_d = StIdle;
                if (gnt_q ? Req0 : Req1) begin
                    launch      = 1'b1;
                    launch_port = ~gnt_q;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (launch) begin
            state_d = StAccess;
            gnt_d   = launch_port;
            we_d    = launch_port ? We1 : We0;
            addr_d  = launch_port ? Addr1 : Addr0;
            wdata_d = launch_port ? WData1 : WData0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q  <= StIdle;
            gnt_q    <= 1'b0;
            rr_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            rr_q     <= rr_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
        end
    end

    // Output decode: strobes and acks are pure functions of the registered state.
    always_comb begin
        Mem_Write  = (state_q == StAccess) && we_q;
        Mem_Read   = (state_q == StAccess) && !we_q;
        Ack0       = (state_q == StResp) && !gnt_q;
        Ack1       = (state_q == StResp) && gnt_q;
        Busy       = (state_q != StIdle);
        Mem_Adresa = addr_q;
        Mem_WData  = wdata_q;
        RData0     = rdata0_q;
        RData1     = rdata1_q;
        GrantCnt0  = cnt0_q;
        GrantCnt1  = cnt1_q;
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: instance 0 is round-robin with 8-bit counters,
// instance 1 is fixed-priority with 2-bit counters. Each has its own DataMemory model.
module tb_data_memory_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [2];
    logic        req0 [2], req1 [2], we0 [2], we1 [2];
    logic [15:0] addr0 [2], addr1 [2], wdata0 [2], wdata1 [2];
    logic        ack0 [2], ack1 [2];
    logic [15:0] rdata0 [2], rdata1 [2];
    logic [15:0] mem_adr [2], mem_wd [2], mem_rd [2];
    logic        mem_w [2], mem_r [2], busy [2];
    logic [7:0]  gcnt0_a, gcnt1_a;
    logic [1:0]  gcnt0_b, gcnt1_b;

    int errors = 0;
    int checks = 0;

    // DataMemory models: synchronous write, combinational read, no reset.
    bit [15:0] mem [2][65536];
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_w[i]) mem[i][mem_adr[i]] <= mem_wd[i];
        end
    end
    assign mem_rd[0] = mem[0][mem_adr[0]];
    assign mem_rd[1] = mem[1][mem_adr[1]];

    data_memory_arbiter #(
        .ADDR_W(16), .DATA_W(16), .FIXED_PRIO(1'b0), .CNT_W(8)
    ) u_dut_rr (
        .Clock(clk), .Reset_n(rst_n[0]),
        .Req0(req0[0]), .Req1(req1[0]), .We0(we0[0]), .We1(we1[0]),
        .Addr0(addr0[0]), .Addr1(addr1[0]), .WData0(wdata0[0]), .WData1(wdata1[0]),
        .Ack0(ack0[0]), .Ack1(ack1[0]), .RData0(rdata0[0]), .RData1(rdata1[0]),
        .Mem_Adresa(mem_adr[0]), .Mem_WData(mem_wd[0]), .Mem_Write(mem_w[0]),
        .Mem_Read(mem_r[0]), .Mem_RData(mem_rd[0]), .Busy(busy[0]),
        .GrantCnt0(gcnt0_a), .GrantCnt1(gcnt1_a)
    );

    data_memory_arbiter #(
        .ADDR_W(16), .DATA_W(16), .FIXED_PRIO(1'b1), .CNT_W(2)
    ) u_dut_fp (
        .Clock(clk), .Reset_n(rst_n[1]),
        .Req0(req0[1]), .Req1(req1[1]), .We0(we0[1]), .We1(we1[1]),
        .Addr0(addr0[1]), .Addr1(addr1[1]), .WData0(wdata0[1]), .WData1(wdata1[1]),
        .Ack0(ack0[1]), .Ack1(ack1[1]), .RData0(rdata0[1]), .RData1(rdata1[1]),
        .Mem_Adresa(mem_adr[1]), .Mem_WData(mem_wd[1]), .Mem_Write(mem_w[1]),
        .Mem_Read(mem_r[1]), .Mem_RData(mem_rd[1]), .Busy(busy[1]),
        .GrantCnt0(gcnt0_b), .GrantCnt1(gcnt1_b)
    );

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic get_req(input int i, input bit p);
        return p ? req1[i] : req0[i];
    endfunction
    function automatic logic get_we(input int i, input bit p);
        return p ? we1[i] : we0[i];
    endfunction
    function automatic logic [15:0] get_addr(input int i, input bit p);
        return p ? addr1[i] : addr0[i];
    endfunction
    function automatic logic [15:0] get_wd(input int i, input bit p);
        return p ? wdata1[i] : wdata0[i];
    endfunction
    function automatic logic get_ack(input int i, input bit p);
        return p ? ack1[i] : ack0[i];
    endfunction
    function automatic logic [15:0] get_rd(input int i, input bit p);
        return p ? rdata1[i] : rdata0[i];
    endfunction
    function automatic int get_cnt(input int i, input bit p);
        if (i == 0) return p ? int'(gcnt1_a) : int'(gcnt0_a);
        return p ? int'(gcnt1_b) : int'(gcnt0_b);
    endfunction

    task automatic drive(input int i, input bit p, input bit r, input bit we,
                         input logic [15:0] a, input logic [15:0] d);
        if (p) begin
            req1[i] = r; we1[i] = we; addr1[i] = a; wdata1[i] = d;
        end else begin
            req0[i] = r; we0[i] = we; addr0[i] = a; wdata0[i] = d;
        end
    endtask

    task automatic set_req(input int i, input bit p, input bit r);
        if (p) req1[i] = r;
        else req0[i] = r;
    endtask

    // Transaction-level reference: shared memory image, grant counts, fairness order.
    bit [15:0] gold [2][65536];
    bit        unknown [2][65536];
    int        cnt_m [2][2];
    bit        pref [2];
    bit        exp_v [2];
    bit        exp_p [2];

    task automatic mon_step(input int i);
        int cmax;
        cmax = (i == 0) ? 255 : 3;
        chk("bus_exclusive", 32'({ack0[i] & ack1[i], mem_w[i] & mem_r[i],
                                  !busy[i] & (mem_w[i] | mem_r[i])}), 32'd0);
        for (int p = 0; p < 2; p++) begin
            if (get_ack(i, bit'(p))) begin
                if (exp_v[i]) chk("arb_order", 32'(p), 32'(exp_p[i]));
                exp_v[i] = 1'b0;
                cnt_m[i][p] = (cnt_m[i][p] < cmax) ? cnt_m[i][p] + 1 : cmax;
                chk("grant_cnt", 32'(get_cnt(i, bit'(p))), 32'(cnt_m[i][p]));
                if (get_we(i, bit'(p))) begin
                    gold[i][get_addr(i, bit'(p))]    = get_wd(i, bit'(p));
                    unknown[i][get_addr(i, bit'(p))] = 1'b0;
                end else if (!unknown[i][get_addr(i, bit'(p))]) begin
                    chk("read_data", 32'(get_rd(i, bit'(p))),
                        32'(gold[i][get_addr(i, bit'(p))]));
                end
                pref[i] = ~bit'(p);
                if (get_req(i, ~bit'(p))) begin
                    exp_v[i] = 1'b1;
                    exp_p[i] = ~bit'(p);
                end
            end
        end
        if (rst_n[i] && !busy[i] && (req0[i] || req1[i])) begin
            exp_v[i] = 1'b1;
            if (req0[i] && req1[i]) exp_p[i] = (i == 1) ? 1'b0 : pref[i];
            else exp_p[i] = req1[i];
        end
        if (!rst_n[i]) begin
            for (int p = 0; p < 2; p++) begin
                cnt_m[i][p] = 0;
                // A write caught by reset may or may not have reached memory.
                if (get_req(i, bit'(p)) && get_we(i, bit'(p)))
                    unknown[i][get_addr(i, bit'(p))] = 1'b1;
            end
            pref[i]  = 1'b0;
            exp_v[i] = 1'b0;
        end
    endtask

    task automatic mon_loop();
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) mon_step(i);
        end
    endtask

    task automatic txn(input int i, input bit p, input bit we, input logic [15:0] a,
                       input logic [15:0] d, output logic [15:0] rd, output int lat);
        @(posedge clk); #1;
        drive(i, p, 1'b1, we, a, d);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!get_ack(i, p) && lat < 20);
        rd = get_rd(i, p);
        set_req(i, p, 1'b0);
    endtask

    task automatic run_random(input int ncyc);
        int age [2][2];
        for (int i = 0; i < 2; i++) for (int p = 0; p < 2; p++) age[i][p] = 0;
        for (int c = 0; c < ncyc + 30; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                for (int p = 0; p < 2; p++) begin
                    if (get_req(i, bit'(p))) begin
                        age[i][p]++;
                        if (get_ack(i, bit'(p)) || age[i][p] > 20) begin
                            chk("rand_ack_bound", 32'(age[i][p] <= 20), 32'd1);
                            set_req(i, bit'(p), 1'b0);
                            age[i][p] = 0;
                        end
                    end else if (c < ncyc && $urandom_range(0, 2) == 0) begin
                        drive(i, bit'(p), 1'b1, bit'($urandom_range(0, 1)),
                              16'($urandom_range(0, 31)), 16'($urandom));
                        age[i][p] = 0;
                    end
                end
            end
        end
    endtask

    typedef struct {
        int          inst;
        bit          port;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } vec_t;

    initial begin
        vec_t        tbl [$];
        logic [15:0] rd;
        int          lat;
        int          t0, t1;
        logic [1:0]  exp_pat;

        tbl.push_back('{0, 1'b0, 1'b1, 16'd12, 16'h0012, 16'h0000});
        tbl.push_back('{0, 1'b0, 1'b0, 16'd12, 16'h0000, 16'h0012});
        tbl.push_back('{0, 1'b1, 1'b1, 16'd7,  16'hABCD, 16'h0000});
        tbl.push_back('{0, 1'b1, 1'b0, 16'd7,  16'h0000, 16'hABCD});
        tbl.push_back('{1, 1'b1, 1'b1, 16'd3,  16'h5A5A, 16'h0000});
        tbl.push_back('{1, 1'b0, 1'b0, 16'd3,  16'h0000, 16'h5A5A});
        tbl.push_back('{0, 1'b0, 1'b0, 16'd7,  16'h0000, 16'hABCD});
        tbl.push_back('{0, 1'b1, 1'b0, 16'd12, 16'h0000, 16'h0012});

        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0;
            drive(i, 1'b0, 1'b1, 1'b0, 16'd0, 16'd0);
            drive(i, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
        end
        fork
            mon_loop();
        join_none

        // Reset held with a pending request: nothing may move.
        repeat (3) begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                chk("reset_quiet", 32'({ack0[i], ack1[i], mem_w[i], mem_r[i], busy[i]}), 32'd0);
                chk("reset_cnt", 32'(get_cnt(i, 1'b0) + get_cnt(i, 1'b1)), 32'd0);
            end
        end
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b1;
            set_req(i, 1'b0, 1'b0);
        end

        foreach (tbl[v]) begin
            txn(tbl[v].inst, tbl[v].port, tbl[v].we, tbl[v].addr, tbl[v].wdata, rd, lat);
            chk("vec_latency", 32'(lat), 32'd2);
            if (!tbl[v].we) chk("vec_rdata", 32'(rd), 32'(tbl[v].exp_rd));
        end

        // Simultaneous requests, round-robin favouring port 0: back-to-back grants.
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, 1'b1, 16'd5, 16'h1111);
        drive(0, 1'b1, 1'b1, 1'b1, 16'd6, 16'h2222);
        t0 = -1;
        t1 = -1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (ack0[0] && t0 < 0) begin t0 = k; set_req(0, 1'b0, 1'b0); end
            if (ack1[0] && t1 < 0) begin t1 = k; set_req(0, 1'b1, 1'b0); end
        end
        chk("conflict_ack0_cycle", 32'(t0), 32'd2);
        chk("conflict_ack1_cycle", 32'(t1), 32'd4);
        txn(0, 1'b0, 1'b0, 16'd5, 16'd0, rd, lat);
        chk("conflict_read5", 32'(rd), 32'h1111);
        txn(0, 1'b1, 1'b0, 16'd6, 16'd0, rd, lat);
        chk("conflict_read6", 32'(rd), 32'h2222);

        // Fixed priority, both held: the RESP mask alone forces alternation.
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b1, 1'b1, 16'd40, 16'h0040);
        drive(1, 1'b1, 1'b1, 1'b1, 16'd41, 16'h0041);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k <= 8 && k % 4 == 2) exp_pat = 2'b10;
            else if (k <= 8 && k % 4 == 0) exp_pat = 2'b01;
            else exp_pat = 2'b00;
            chk("fixed_alternate", 32'({ack0[1], ack1[1]}), 32'(exp_pat));
            if (k == 8) begin
                set_req(1, 1'b0, 1'b0);
                set_req(1, 1'b1, 1'b0);
            end
        end

        // Reset during the ACCESS cycle of a port-1 write.
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 1'b1, 16'd20, 16'hBEEF);
        @(posedge clk); #1;
        chk("midreset_write_strobe", 32'(mem_w[0]), 32'd1);
        rst_n[0] = 1'b0;
        @(posedge clk); #1;
        chk("midreset_quiet", 32'({ack1[0], busy[0], mem_w[0]}), 32'd0);
        rst_n[0] = 1'b1;
        set_req(0, 1'b1, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
            chk("midreset_no_ack1", 32'(ack1[0]), 32'd0);
        end
        chk("midreset_cnt1", 32'(gcnt1_a), 32'd0);
        txn(0, 1'b0, 1'b0, 16'd20, 16'd0, rd, lat);
        chk("midreset_read20", 32'(rd), 32'hBEEF);

        // Counter saturation with 2-bit counters.
        @(posedge clk); #1;
        rst_n[1] = 1'b0;
        @(posedge clk); #1;
        rst_n[1] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            txn(1, 1'b0, bit'(k % 2), 16'(k), 16'(k * 3), rd, lat);
            @(posedge clk); #1;
            chk("sat_cnt0", 32'(gcnt0_b), 32'((k < 3) ? k : 3));
            chk("sat_cnt1", 32'(gcnt1_b), 32'd0);
        end

        run_random(1500);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
